// File: rtl/seed_writer.sv
// Seed loader: assembles sixteen 64-bit squeeze words into rho, rho' and K,
// emitting one registered write pulse per completed field.
module seed_writer #(
   parameter int W_WORD = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   input  logic [W_WORD-1:0]   in_data,
   output logic                in_ready,
   output logic                Rho_en,
   output logic [4*W_WORD-1:0] Rho_din,
   output logic                Rho_prime_en,
   output logic [8*W_WORD-1:0] Rho_prime_din,
   output logic                Kata_en,
   output logic [4*W_WORD-1:0] Kata_din,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {S_IDLE, S_LD_RHO, S_LD_RHOP, S_LD_KATA} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic [4*W_WORD-1:0] r_rho;
   logic [8*W_WORD-1:0] r_rhop;
   logic [4*W_WORD-1:0] r_kata;
   logic                r_rho_en;
   logic                r_rhop_en;
   logic                r_kata_en;
   logic                w_hs;
   logic                w_load;
   logic                w_rho_last;
   logic                w_rhop_last;
   logic                w_kata_last;
   logic [2:0]          w_pidx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start)       w_next = S_LD_RHO;
         S_LD_RHO:  if (w_rho_last)  w_next = S_LD_RHOP;
         S_LD_RHOP: if (w_rhop_last) w_next = S_LD_KATA;
         S_LD_KATA: if (w_kata_last) w_next = S_IDLE;
         default:                    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (r_state != S_IDLE);
      busy        = (r_state != S_IDLE);
      w_hs        = in_valid & in_ready;
      w_load      = (r_state == S_IDLE) & start;
      w_rho_last  = w_hs & (r_state == S_LD_RHO)  & (r_cnt == 4'd3);
      w_rhop_last = w_hs & (r_state == S_LD_RHOP) & (r_cnt == 4'd11);
      w_kata_last = w_hs & (r_state == S_LD_KATA) & (r_cnt == 4'd15);
   end

   // rho' lanes start at global word 4
   assign w_pidx = 3'(r_cnt - 4'd4);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rho_en  <= 1'b0;
         r_rhop_en <= 1'b0;
         r_kata_en <= 1'b0;
      end else begin
         r_rho_en  <= w_rho_last;
         r_rhop_en <= w_rhop_last;
         r_kata_en <= w_kata_last;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_rho  <= '0;
         r_rhop <= '0;
         r_kata <= '0;
      end else if (w_load) begin
         r_cnt  <= '0;
         r_rho  <= '0;
         r_rhop <= '0;
         r_kata <= '0;
      end else if (w_hs) begin
         r_cnt <= r_cnt + 4'd1;
         case (r_state)
            S_LD_RHO:
               for (int i = 0; i < 4; i++)
                  if (r_cnt[1:0] == 2'(i)) r_rho[i*W_WORD +: W_WORD] <= in_data;
            S_LD_RHOP:
               for (int i = 0; i < 8; i++)
                  if (w_pidx == 3'(i)) r_rhop[i*W_WORD +: W_WORD] <= in_data;
            S_LD_KATA:
               for (int i = 0; i < 4; i++)
                  if (r_cnt[1:0] == 2'(i)) r_kata[i*W_WORD +: W_WORD] <= in_data;
            default: ;
         endcase
      end
   end

   assign Rho_en        = r_rho_en;
   assign Rho_prime_en  = r_rhop_en;
   assign Kata_en       = r_kata_en;
   assign done          = r_kata_en;
   assign Rho_din       = r_rho;
   assign Rho_prime_din = r_rhop;
   assign Kata_din      = r_kata;

endmodule

// File: tb/tb_seed_writer.sv
// Scoreboard bench for seed_writer: the driver pushes expected field writes,
// a negedge monitor pops and checks them whenever a write pulse appears.
module tb_seed_writer;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic [63:0]  in_data = '0;
   logic         in_ready;
   logic         Rho_en, Rho_prime_en, Kata_en, busy, done;
   logic [255:0] Rho_din, Kata_din;
   logic [511:0] Rho_prime_din;

   seed_writer #(.W_WORD(64)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready),
      .Rho_en(Rho_en), .Rho_din(Rho_din),
      .Rho_prime_en(Rho_prime_en), .Rho_prime_din(Rho_prime_din),
      .Kata_en(Kata_en), .Kata_din(Kata_din),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           kind;   // 0 rho, 1 rho', 2 K
      int           cyc;
      logic [511:0] data;
   } exp_t;

   exp_t         sb[$];
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_fail = 0;
   logic [63:0]  words[16];
   logic [511:0] m_rho, m_rhop, m_kata;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: a field is the little-endian concatenation of its words.
   function automatic logic [511:0] field(input int base, input int n);
      logic [511:0] v = '0;
      for (int j = 0; j < n; j++) v[64*j +: 64] = words[base+j];
      return v;
   endfunction

   task automatic push(input int kind);
      exp_t e;
      e.kind = kind;
      e.cyc  = cyc + 1;
      e.data = (kind == 0) ? field(0, 4) : (kind == 1) ? field(4, 8) : field(12, 4);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (done || Kata_en) begin
            check("done_with_kata", 512'(done), 512'(Kata_en));
            check("busy_at_done", 512'(busy), 512'd0);
         end
         if (Rho_en || Rho_prime_en || Kata_en) begin
            int   k;
            logic [511:0] act;
            k   = Rho_en ? 0 : Rho_prime_en ? 1 : 2;
            act = (k == 0) ? 512'(Rho_din) : (k == 1) ? Rho_prime_din : 512'(Kata_din);
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_pulse: got field %0d at cycle %0d, expected none", k, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (k != e.kind) begin
                  n_fail++;
                  $display("FAIL pulse_order: got field %0d expected field %0d", k, e.kind);
               end
               check("pulse_cycle", 512'(cyc), 512'(e.cyc));
               check("field_data", act, e.data);
               check("single_enable", 512'(32'(Rho_en) + 32'(Rho_prime_en) + 32'(Kata_en)), 512'd1);
            end
         end
      end
   end

   // mode 0: back-to-back, 1: in_valid toggling, 2: random gaps
   task automatic run_load(input int mode, input bit restart5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 512'(busy), 512'd1);
      check("ready_after_start", 512'(in_ready), 512'd1);
      check("din_zeroed", 512'({Rho_din, Kata_din}) | Rho_prime_din, 512'd0);
      for (int i = 0; i < 16; i++) begin
         int gap;
         gap = (mode == 1 && i > 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 64'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = words[i];
         start    = restart5 && (i == 5);
         if (i == 3)  push(0);
         if (i == 11) push(1);
         if (i == 15) push(2);
         @(posedge clk); #1;
         in_valid = 1'b0;
         start    = 1'b0;
      end
      m_rho  = field(0, 4);
      m_rhop = field(4, 8);
      m_kata = field(12, 4);
   endtask

   initial begin
      #23;
      check("rst_outputs", 512'({in_ready, busy, done, Rho_en, Rho_prime_en, Kata_en}), 512'd0);
      check("rst_din", 512'({Rho_din, Kata_din}) | Rho_prime_din, 512'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset during word 6: rho already written, rest discarded.
      for (int i = 0; i < 16; i++) words[i] = 64'(i);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = words[i];
         if (i == 3) push(0);
         @(posedge clk); #1;
      end
      in_data = words[6];
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy", 512'({busy, in_ready}), 512'd0);
      check("rst_mid_din", 512'({Rho_din, Kata_din}) | Rho_prime_din, 512'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_restart", 512'(busy), 512'd0);

      // Words 0..15 back-to-back, then with toggling valid, then restart at 5.
      run_load(0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("hold_rho", 512'(Rho_din), m_rho);
      check("hold_rhop", Rho_prime_din, m_rhop);
      check("hold_kata", 512'(Kata_din), m_kata);
      run_load(1, 1'b0);
      @(posedge clk); #1;
      run_load(0, 1'b1);
      @(posedge clk); #1;

      // Idle traffic must not be consumed.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 64'($urandom);
         @(posedge clk); #1;
         check("idle_ready", 512'({in_ready, busy}), 512'd0);
      end
      in_valid = 1'b0;
      check("idle_rho", 512'(Rho_din), m_rho);
      check("idle_rhop", Rho_prime_din, m_rhop);
      check("idle_kata", 512'(Kata_din), m_kata);

      // Back-to-back loads: second start in the done cycle.
      run_load(0, 1'b0);
      for (int i = 0; i < 16; i++) words[i] = 64'hA0 + 64'(i);
      run_load(0, 1'b0);
      #1;
      check("b2b_rho", 512'(Rho_din), {256'd0, 64'hA3, 64'hA2, 64'hA1, 64'hA0});

      // Randomized loads with random gaps.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 16; i++) words[i] = {32'($urandom), 32'($urandom)};
         run_load(2, n[0]);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      #1;
      check("sb_drained", 512'(sb.size()), 512'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
